// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator_pkg
//  Description : Router-wide NoC parameters and the output-port type shared
//                by the switch allocator and its arbiters.
//  Revision    : 1.0  initial release
// ============================================================================
package switch_allocator_pkg;

   localparam int NOC_PORT_NUM  = 5;
   localparam int NOC_VC_NUM    = 2;
   localparam int NOC_VC_SIZE   = (NOC_VC_NUM   > 1) ? $clog2(NOC_VC_NUM)   : 1;
   localparam int NOC_PORT_SIZE = (NOC_PORT_NUM > 1) ? $clog2(NOC_PORT_NUM) : 1;

   // Router output ports, in crossbar index order
   typedef enum logic [NOC_PORT_SIZE-1:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      EAST  = 3'd4
   } port_t;

endpackage
`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter
//  Description : N-way round-robin arbiter. Search starts at the internal
//                pointer; the pointer moves past the winner only when the
//                caller asserts update (i.e. the grant was actually used).
//  Revision    : 1.0  initial release
// ============================================================================
module round_robin_arbiter
   import switch_allocator_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             update,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] r_ptr;
   logic             w_found;

   // (base + off) mod N for off < N, without a divider
   function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                               input int unsigned     off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   // First requester at or after the pointer wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!w_found && req[f_wrap(r_ptr, k)]) begin
            grant[f_wrap(r_ptr, k)] = 1'b1;
            grant_idx               = f_wrap(r_ptr, k);
            w_found                 = 1'b1;
         end
      end
   end

   // Pointer moves one past the winner on a used grant, otherwise holds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_ptr <= '0;
      else if (update)
         r_ptr <= f_wrap(grant_idx, 1);
   end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Separable input-first switch allocator. Stage 1 picks one
//                eligible VC per input, stage 2 picks one nominee per output.
//                VC grants are combinational; crossbar selects are registered.
//                Optional macro SA_PKT_LOCK_EN adds a wormhole packet lock per
//                output (lock set by a non-tail grant, cleared by the tail).
//  Revision    : 1.0  initial release
// ============================================================================
module switch_allocator
   import switch_allocator_pkg::*;
#(
   parameter  int PORT_NUM  = NOC_PORT_NUM,
   parameter  int VC_NUM    = NOC_VC_NUM,
   localparam int VC_SIZE   = (VC_NUM   > 1) ? $clog2(VC_NUM)   : 1,
   localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
)
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]    ib_req,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0]    ib_out_port,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]    ib_tail,
   input  logic  [PORT_NUM-1:0]                ds_ready,
   output logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel,
   output logic  [PORT_NUM-1:0]                valid_sel,
   output logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel,
   output logic  [PORT_NUM-1:0]                xb_valid
);

   logic  [PORT_NUM-1:0][VC_NUM-1:0]    w_elig;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]    w_s1_req;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]    w_s1_grant;
   logic  [PORT_NUM-1:0][VC_SIZE-1:0]   w_nom;
   logic  [PORT_NUM-1:0]                w_nom_valid;
   port_t [PORT_NUM-1:0]                w_nom_port;
   logic  [PORT_NUM-1:0][PORT_NUM-1:0]  w_s2_req;     // [output][input]
   logic  [PORT_NUM-1:0][PORT_NUM-1:0]  w_s2_grant;   // [output][input]
   logic  [PORT_NUM-1:0][PORT_SIZE-1:0] w_win;
   logic  [PORT_NUM-1:0]                w_out_busy;
   logic  [PORT_NUM-1:0]                w_s2_upd;
   logic  [PORT_NUM-1:0]                w_in_win;
   logic  [PORT_NUM-1:0][PORT_SIZE-1:0] r_xb_sel;
   logic  [PORT_NUM-1:0]                r_xb_valid;

   // A VC may compete only if its target output can accept a flit
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < PORT_NUM; i++)
         for (int v = 0; v < VC_NUM; v++)
            w_elig[i][v] = ib_req[i][v] & ds_ready[ib_out_port[i][v]];
   end

`ifdef SA_PKT_LOCK_EN
   typedef struct packed {
      logic                 valid;
      logic [PORT_SIZE-1:0] src;
      logic [VC_SIZE-1:0]   vc;
   } lock_t;

   lock_t [PORT_NUM-1:0]             r_lock;
   logic  [PORT_NUM-1:0][VC_NUM-1:0] w_pref;
   logic  [PORT_NUM-1:0]             w_win_tail;

   // VCs that own an output lock and can send now are preferred at their input
   always_comb begin
      w_pref = '0;
      for (int o = 0; o < PORT_NUM; o++)
         if (r_lock[o].valid && w_elig[r_lock[o].src][r_lock[o].vc])
            w_pref[r_lock[o].src][r_lock[o].vc] = 1'b1;
   end

   // Restrict stage 1 to the preferred VCs when any exist
   always_comb begin
      w_s1_req = '0;
      for (int i = 0; i < PORT_NUM; i++)
         w_s1_req[i] = (|w_pref[i]) ? w_pref[i] : w_elig[i];
   end
`else
   logic w_unused_tail;

   assign w_s1_req      = w_elig;
   assign w_unused_tail = ^ib_tail;
`endif

   // Stage 1: one VC nominee per input
   for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_in_arb
      round_robin_arbiter #(.N(VC_NUM)) u_arb (
         .clk       (clk),
         .rst       (rst),
         .req       (w_s1_req[gi]),
         .update    (w_in_win[gi]),
         .grant     (w_s1_grant[gi]),
         .grant_idx (w_nom[gi])
      );
      assign w_nom_valid[gi] = |w_s1_grant[gi];
      assign w_nom_port[gi]  = ib_out_port[gi][w_nom[gi]];
   end

   // Each nominee requests its output; a locked output only hears its owner
   always_comb begin
      w_s2_req = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            if (w_nom_valid[i] && (int'(w_nom_port[i]) == o))
               w_s2_req[o][i] = 1'b1;
`ifdef SA_PKT_LOCK_EN
            if (r_lock[o].valid &&
                ((r_lock[o].src != PORT_SIZE'(i)) || (r_lock[o].vc != w_nom[i])))
               w_s2_req[o][i] = 1'b0;
`endif
         end
      end
   end

   // Stage 2: one input per output
   for (genvar go = 0; go < PORT_NUM; go++) begin : g_out_arb
      round_robin_arbiter #(.N(PORT_NUM)) u_arb (
         .clk       (clk),
         .rst       (rst),
         .req       (w_s2_req[go]),
         .update    (w_s2_upd[go]),
         .grant     (w_s2_grant[go]),
         .grant_idx (w_win[go])
      );
      assign w_out_busy[go] = |w_s2_grant[go];
`ifdef SA_PKT_LOCK_EN
      // Output pointer only moves once the packet that held it has finished
      assign w_win_tail[go] = ib_tail[w_win[go]][w_nom[w_win[go]]];
      assign w_s2_upd[go]   = w_out_busy[go] & w_win_tail[go];
`else
      assign w_s2_upd[go]   = w_out_busy[go];
`endif
   end

   // Fold output grants back to the inputs that won them
   always_comb begin
      w_in_win = '0;
      for (int o = 0; o < PORT_NUM; o++)
         for (int i = 0; i < PORT_NUM; i++)
            if (w_s2_grant[o][i])
               w_in_win[i] = 1'b1;
   end

   // Grants are suppressed while reset is held; losers report VC 0
   always_comb begin
      valid_sel = w_in_win & {PORT_NUM{rst}};
      vc_sel    = '0;
      for (int i = 0; i < PORT_NUM; i++)
         vc_sel[i] = valid_sel[i] ? w_nom[i] : '0;
   end

`ifdef SA_PKT_LOCK_EN
   // Non-tail grant claims the output for that VC, tail grant releases it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lock <= '0;
      end else begin
         for (int o = 0; o < PORT_NUM; o++) begin
            if (w_out_busy[o]) begin
               if (w_win_tail[o]) begin
                  r_lock[o] <= '0;
               end else begin
                  r_lock[o].valid <= 1'b1;
                  r_lock[o].src   <= w_win[o];
                  r_lock[o].vc    <= w_nom[w_win[o]];
               end
            end
         end
      end
   end
`endif

   // Register the stage-2 result for the switch-traversal stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_xb_valid <= '0;
         r_xb_sel   <= '0;
      end else begin
         r_xb_valid <= w_out_busy;
         r_xb_sel   <= w_win;
      end
   end

   assign xb_sel   = r_xb_sel;
   assign xb_valid = r_xb_valid;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_allocator
//  Description : Self-checking bench for switch_allocator: directed scenarios
//                with literal expectations plus a short random phase, all
//                cross-checked every cycle by a behavioural allocator model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_switch_allocator;
   import switch_allocator_pkg::*;

   localparam int P = NOC_PORT_NUM;
   localparam int V = NOC_VC_NUM;

   logic                              clk = 1'b0;
   logic                              rst;
   logic  [P-1:0][V-1:0]              ib_req;
   port_t [P-1:0][V-1:0]              ib_out_port;
   logic  [P-1:0][V-1:0]              ib_tail;
   logic  [P-1:0]                     ds_ready;
   logic  [P-1:0][NOC_VC_SIZE-1:0]    vc_sel;
   logic  [P-1:0]                     valid_sel;
   logic  [P-1:0][NOC_PORT_SIZE-1:0]  xb_sel;
   logic  [P-1:0]                     xb_valid;

   int n_checks = 0;
   int n_fail   = 0;

   switch_allocator dut (
      .clk         (clk),
      .rst         (rst),
      .ib_req      (ib_req),
      .ib_out_port (ib_out_port),
      .ib_tail     (ib_tail),
      .ds_ready    (ds_ready),
      .vc_sel      (vc_sel),
      .valid_sel   (valid_sel),
      .xb_sel      (xb_sel),
      .xb_valid    (xb_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit elig(input int i, input int v);
      return ib_req[i][v] && ds_ready[ib_out_port[i][v]];
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   int m_in_ptr [P];
   int m_out_ptr[P];
   bit m_xb_v   [P];
   int m_xb_s   [P];
   bit m_lk_v   [P];
   int m_lk_i   [P];
   int m_lk_vc  [P];

   always @(negedge clk) begin : model
      int nom[P];
      int win[P];
      bit pref[V];
      bit pref_any;
      bit ok;
      int i, v;
      logic [P-1:0]                    e_valid;
      logic [P-1:0][NOC_VC_SIZE-1:0]   e_vc;
      logic [P-1:0]                    e_xbv;
      logic [P-1:0][NOC_PORT_SIZE-1:0] e_xbs, a_xbs;
      if (!rst) begin
         check("reset_valid_sel", 32'(valid_sel), 32'd0);
         check("reset_xb_valid", 32'(xb_valid), 32'd0);
         for (int o = 0; o < P; o++) begin
            m_in_ptr[o] = 0; m_out_ptr[o] = 0;
            m_xb_v[o] = 1'b0; m_xb_s[o] = 0; m_lk_v[o] = 1'b0;
         end
      end else begin
         // crossbar registers must reflect the previous cycle's grants
         for (int o = 0; o < P; o++) begin
            e_xbv[o] = m_xb_v[o];
            e_xbs[o] = m_xb_v[o] ? NOC_PORT_SIZE'(m_xb_s[o]) : '0;
            a_xbs[o] = xb_valid[o] ? xb_sel[o] : '0;
         end
         check("model_xb_valid", 32'(xb_valid), 32'(e_xbv));
         check("model_xb_sel", 32'(a_xbs), 32'(e_xbs));

         // input stage: round-robin over eligible VCs from the input pointer
         for (int ii = 0; ii < P; ii++) begin
            nom[ii] = -1;
            pref_any = 1'b0;
            for (int k = 0; k < V; k++) pref[k] = 1'b0;
`ifdef SA_PKT_LOCK_EN
            for (int o = 0; o < P; o++)
               if (m_lk_v[o] && m_lk_i[o] == ii && elig(ii, m_lk_vc[o])) begin
                  pref[m_lk_vc[o]] = 1'b1;
                  pref_any = 1'b1;
               end
`endif
            for (int k = 0; k < V; k++) begin
               v = (m_in_ptr[ii] + k) % V;
               if (nom[ii] < 0 && elig(ii, v) && (!pref_any || pref[v])) nom[ii] = v;
            end
         end

         // output stage: round-robin over inputs whose nominee targets it
         for (int o = 0; o < P; o++) begin
            win[o] = -1;
            for (int k = 0; k < P; k++) begin
               i = (m_out_ptr[o] + k) % P;
               if (win[o] < 0 && nom[i] >= 0 && int'(ib_out_port[i][nom[i]]) == o) begin
                  ok = 1'b1;
`ifdef SA_PKT_LOCK_EN
                  if (m_lk_v[o] && !(m_lk_i[o] == i && m_lk_vc[o] == nom[i])) ok = 1'b0;
`endif
                  if (ok) win[o] = i;
               end
            end
         end

         e_valid = '0;
         e_vc    = '0;
         for (int o = 0; o < P; o++)
            if (win[o] >= 0) begin
               e_valid[win[o]] = 1'b1;
               e_vc[win[o]]    = NOC_VC_SIZE'(nom[win[o]]);
            end
         check("model_valid_sel", 32'(valid_sel), 32'(e_valid));
         check("model_vc_sel", 32'(vc_sel), 32'(e_vc));

         // state for next cycle
         for (int ii = 0; ii < P; ii++)
            if (e_valid[ii]) m_in_ptr[ii] = (nom[ii] + 1) % V;
         for (int o = 0; o < P; o++) begin
            m_xb_v[o] = (win[o] >= 0);
            m_xb_s[o] = (win[o] >= 0) ? win[o] : 0;
            if (win[o] >= 0) begin
`ifdef SA_PKT_LOCK_EN
               if (ib_tail[win[o]][nom[win[o]]]) begin
                  m_lk_v[o]    = 1'b0;
                  m_out_ptr[o] = (win[o] + 1) % P;
               end else begin
                  m_lk_v[o]  = 1'b1;
                  m_lk_i[o]  = win[o];
                  m_lk_vc[o] = nom[win[o]];
               end
`else
               m_out_ptr[o] = (win[o] + 1) % P;
`endif
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      ib_req   = '0;
      ib_tail  = '1;
      ds_ready = '1;
      for (int i = 0; i < P; i++)
         for (int v = 0; v < V; v++)
            ib_out_port[i][v] = LOCAL;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b0;
      clear_inputs();
      mid();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_win[6];
      rst = 1'b0;
      clear_inputs();

      // reset held with live requests, then release
      for (int i = 0; i < P; i++) begin
         ib_req[i][0]      = 1'b1;
         ib_out_port[i][0] = port_t'(3'(i));
      end
      mid();
      check("t1_valid_in_reset", 32'(valid_sel), 32'd0);
      check("t1_xbv_in_reset", 32'(xb_valid), 32'd0);
      tick();
      rst = 1'b1;
      mid();
      check("t1_valid_after_release", 32'(valid_sel), 32'h1f);
      check("t1_vc_after_release", 32'(vc_sel), 32'd0);
      tick();
      mid();
      check("t1_xb_valid", 32'(xb_valid), 32'h1f);
      for (int o = 0; o < P; o++) check("t1_xb_sel", 32'(xb_sel[o]), 32'(o));

      // single request (2,1) -> EAST
      do_reset();
      ib_req[2][1]      = 1'b1;
      ib_out_port[2][1] = EAST;
      mid();
      check("t2_valid_sel", 32'(valid_sel), 32'h04);
      check("t2_vc_sel2", 32'(vc_sel[2]), 32'd1);
      tick();
      clear_inputs();
      mid();
      check("t2_idle_valid", 32'(valid_sel), 32'd0);
      check("t2_xb_valid", 32'(xb_valid), 32'h10);
      check("t2_xb_sel_east", 32'(xb_sel[EAST]), 32'd2);
      tick();
      mid();
      check("t2_xb_valid_idle", 32'(xb_valid), 32'd0);

      // output conflict on LOCAL: inputs 0,1,3 rotate
      do_reset();
      ib_req[0][0] = 1'b1;
      ib_req[1][0] = 1'b1;
      ib_req[3][0] = 1'b1;
      exp_win = '{0, 1, 3, 0, 1, 3};
      for (int k = 0; k < 6; k++) begin
         mid();
         check("t3_conflict_winner", 32'(valid_sel), 32'd1 << exp_win[k]);
         tick();
      end

      // VC fairness at input 4
      do_reset();
      ib_req[4]         = 2'b11;
      ib_out_port[4][0] = NORTH;
      ib_out_port[4][1] = SOUTH;
      for (int k = 0; k < 4; k++) begin
         mid();
         check("t4_valid4", 32'(valid_sel[4]), 32'd1);
         check("t4_vc4_alternates", 32'(vc_sel[4]), 32'(k % 2));
         tick();
      end

      // backpressure on WEST
      do_reset();
      ds_ready          = 5'b10111;
      ib_req[1]         = 2'b11;
      ib_out_port[1][0] = WEST;
      ib_out_port[1][1] = EAST;
      for (int k = 0; k < 3; k++) begin
         mid();
         check("t5_valid1", 32'(valid_sel), 32'h02);
         check("t5_vc1_east", 32'(vc_sel[1]), 32'd1);
         check("t5_west_idle", 32'(xb_valid[WEST]), 32'd0);
         tick();
      end
      ds_ready = '1;
      mid();
      check("t5_vc1_west", 32'(vc_sel[1]), 32'd0);
      tick();
      mid();
      check("t5_xbv_west", 32'(xb_valid[WEST]), 32'd1);
      check("t5_xbs_west", 32'(xb_sel[WEST]), 32'd1);

`ifdef SA_PKT_LOCK_EN
      // packet lock on NORTH: input 0 packet holds the output until its tail
      do_reset();
      ib_req[0][0] = 1'b1; ib_out_port[0][0] = NORTH; ib_tail[0][0] = 1'b0;
      ib_req[2][1] = 1'b1; ib_out_port[2][1] = NORTH; ib_tail[2][1] = 1'b1;
      mid();
      check("t6_head", 32'(valid_sel), 32'h01);
      tick();
      mid();
      check("t6_body", 32'(valid_sel), 32'h01);
      check("t6_xbs_head", 32'(xb_sel[NORTH]), 32'd0);
      tick();
      ib_tail[0][0] = 1'b1;
      mid();
      check("t6_tail", 32'(valid_sel), 32'h01);
      tick();
      ib_req[0][0] = 1'b0;
      mid();
      check("t6_after_tail", 32'(valid_sel), 32'h04);
      check("t6_vc2", 32'(vc_sel[2]), 32'd1);
      tick();
      mid();
      check("t6_xbs_in2", 32'(xb_sel[NORTH]), 32'd2);
`endif

      // random traffic checked by the model, with one asynchronous reset
      do_reset();
      for (int k = 0; k < 300; k++) begin
         ib_req   = 10'($urandom);
         ib_tail  = 10'($urandom) | 10'($urandom);
         ds_ready = 5'($urandom) | 5'($urandom);
         for (int i = 0; i < P; i++)
            for (int v = 0; v < V; v++)
               ib_out_port[i][v] = port_t'(3'($urandom_range(0, P - 1)));
         if (k == 150) begin
            #2;
            rst = 1'b0;
         end
         tick();
         rst = 1'b1;
      end

      clear_inputs();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
